// File: rtl/keypad_pkg.sv
// Shared constants, scan state encoding and key-position helpers for the
// 3x3 keypad scan sequencer and its event FIFO.
package keypad_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 9;
  localparam int POS_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_EVAL   = 2'd3
  } scan_state_t;

  // Position of the key at (row, column): 3*row + column.
  function automatic logic [POS_W-1:0] key_pos(input logic [1:0] row_idx,
                                               input logic [1:0] col_idx);
    return ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx};
  endfunction

  // Number of keys down in a frame.
  function automatic logic [3:0] key_count(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt = cnt + {3'b000, keys[i]};
    end
    return cnt;
  endfunction

  // Position of the lowest key down; only meaningful for single-key frames.
  function automatic logic [POS_W-1:0] key_index(input logic [NUM_KEYS-1:0] keys);
    logic [POS_W-1:0] idx;
    idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        idx = POS_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small circular FIFO holding key position events until the game logic
// pops them. A push into a full FIFO only succeeds if a pop happens in
// the same cycle; pops on an empty FIFO are ignored.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = POS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = (count_r != {CNT_W{1'b0}});
  assign full  = (count_r == CNT_W'(DEPTH));
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/keypad_scan_sequencer.sv
// Scans a 3x3 active-low keypad one column at a time, debounces each full
// 9-key frame and queues single-key presses as position events (0-8).
module keypad_scan_sequencer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       row,
  output logic [2:0]       column,
  output logic             key_valid,
  output logic [POS_W-1:0] key_position,
  input  logic             key_ready,
  output logic             key_held,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 2);
  localparam logic [3:0]        DEB_MAX   = 4'(DEBOUNCE_SCANS);

  scan_state_t          state_r;
  scan_state_t          state_next_s;
  logic [1:0]           col_r;
  logic [1:0]           col_next_s;
  logic [SLOT_W-1:0]    slot_r;
  logic [SLOT_W-1:0]    slot_next_s;
  logic [2:0]           column_r;
  logic [2:0]           column_next_s;

  logic [NUM_KEYS-1:0]  frame_r;
  logic [NUM_KEYS-1:0]  frame_next_s;
  logic [NUM_KEYS-1:0]  prev_frame_r;
  logic [NUM_KEYS-1:0]  accepted_r;
  logic [3:0]           stable_cnt_r;
  logic [3:0]           cnt_eval_s;
  logic                 accept_s;
  logic                 event_s;
  logic [POS_W-1:0]     event_pos_s;
  logic                 key_held_r;
  logic                 overflow_r;
  logic                 drop_s;

  logic                 fifo_valid_s;
  logic                 fifo_full_s;
  logic [POS_W-1:0]     fifo_head_s;

  // Scan state, column index, slot counter and column strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      col_r    <= 2'd0;
      slot_r   <= {SLOT_W{1'b0}};
      column_r <= 3'b111;
    end else begin
      state_r  <= state_next_s;
      col_r    <= col_next_s;
      slot_r   <= slot_next_s;
      column_r <= column_next_s;
    end
  end

  // Next scan state; dropping enable abandons the frame at once.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_next_s = ST_DRIVE;
        else        state_next_s = ST_IDLE;
      end
      ST_DRIVE: begin
        if (!enable)                 state_next_s = ST_IDLE;
        else if (slot_r == SLOT_LAST) state_next_s = ST_SAMPLE;
        else                         state_next_s = ST_DRIVE;
      end
      ST_SAMPLE: begin
        if (!enable)            state_next_s = ST_IDLE;
        else if (col_r == 2'd2) state_next_s = ST_EVAL;
        else                    state_next_s = ST_DRIVE;
      end
      ST_EVAL: begin
        if (enable) state_next_s = ST_DRIVE;
        else        state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Column index and settle-slot counter for the next cycle.
  always_comb begin
    col_next_s  = 2'd0;
    slot_next_s = {SLOT_W{1'b0}};
    case (state_r)
      ST_DRIVE: begin
        if (state_next_s == ST_DRIVE) begin
          col_next_s  = col_r;
          slot_next_s = slot_r + SLOT_W'(1);
        end else if (state_next_s == ST_SAMPLE) begin
          col_next_s  = col_r;
          slot_next_s = {SLOT_W{1'b0}};
        end else begin
          col_next_s  = 2'd0;
          slot_next_s = {SLOT_W{1'b0}};
        end
      end
      ST_SAMPLE: begin
        if (state_next_s == ST_DRIVE) col_next_s = col_r + 2'd1;
        else                          col_next_s = 2'd0;
      end
      default: begin
        col_next_s  = 2'd0;
        slot_next_s = {SLOT_W{1'b0}};
      end
    endcase
  end

  // Column strobes decoded from the upcoming state so they come out of a flop.
  always_comb begin
    column_next_s = 3'b111;
    if ((state_next_s == ST_DRIVE) || (state_next_s == ST_SAMPLE)) begin
      case (col_next_s)
        2'd0:    column_next_s = 3'b110;
        2'd1:    column_next_s = 3'b101;
        2'd2:    column_next_s = 3'b011;
        default: column_next_s = 3'b111;
      endcase
    end else begin
      column_next_s = 3'b111;
    end
  end

  // Frame with the current column's rows merged in (rows are active-low).
  always_comb begin
    frame_next_s = frame_r;
    for (int r = 0; r < NUM_ROWS; r++) begin
      frame_next_s[key_pos(2'(r), col_r)] = ~row[r];
    end
  end

  // Debounce decision for the frame just completed.
  always_comb begin
    if (frame_r == prev_frame_r) begin
      if (stable_cnt_r >= DEB_MAX) cnt_eval_s = DEB_MAX;
      else                         cnt_eval_s = stable_cnt_r + 4'd1;
    end else begin
      cnt_eval_s = 4'd1;
    end
    accept_s    = (state_r == ST_EVAL) && (cnt_eval_s == DEB_MAX) &&
                  (frame_r != accepted_r);
    event_s     = accept_s && (key_count(frame_r) == 4'd1) &&
                  ((frame_r & ~accepted_r) != 9'd0);
    event_pos_s = key_index(frame_r);
    drop_s      = event_s && fifo_full_s && !(fifo_valid_s && key_ready);
  end

  // Frame capture, stability counting and accepted key state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_r      <= 9'd0;
      prev_frame_r <= 9'd0;
      accepted_r   <= 9'd0;
      stable_cnt_r <= 4'd0;
      key_held_r   <= 1'b0;
    end else begin
      if (state_r == ST_SAMPLE) begin
        frame_r <= frame_next_s;
      end
      if (state_r == ST_EVAL) begin
        prev_frame_r <= frame_r;
        stable_cnt_r <= cnt_eval_s;
        if (accept_s) begin
          accepted_r <= frame_r;
          key_held_r <= |frame_r;
        end
      end else if (((state_r == ST_DRIVE) || (state_r == ST_SAMPLE)) && !enable) begin
        stable_cnt_r <= 4'd0;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  key_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (POS_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (event_s),
    .push_data (event_pos_s),
    .pop       (key_ready),
    .valid     (fifo_valid_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s)
  );

  assign column       = column_r;
  assign key_valid    = fifo_valid_s;
  assign key_position = fifo_head_s;
  assign key_held     = key_held_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Randomized and directed bench for keypad_scan_sequencer. A physical keypad
// model drives the rows; a frame-level reference model predicts events.
module tb_keypad_scan_sequencer;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 3 * SCAN_DIV + 1;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] row;
  logic [2:0] column;
  logic       key_valid;
  logic [3:0] key_position;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       clear_overflow;
  logic [8:0] pressed;

  int errors;
  int checks;

  // reference model state
  logic [3:0] mq[$];
  logic [8:0] hist[$];
  logic [8:0] m_acc;
  bit         m_ovf;

  keypad_scan_sequencer #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .row            (row),
    .column         (column),
    .key_valid      (key_valid),
    .key_position   (key_position),
    .key_ready      (key_ready),
    .key_held       (key_held),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is low.
  function automatic logic [2:0] keypad_rows(input logic [8:0] k, input logic [2:0] col);
    logic [2:0] r;
    r = 3'b111;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        if (!col[cc] && k[3*rr+cc]) r[rr] = 1'b0;
    return r;
  endfunction

  assign row = keypad_rows(pressed, column);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_column(input int i);
    logic [2:0] c;
    if (i < 3 * SCAN_DIV) c = ~(3'b001 << (i / SCAN_DIV));
    else                  c = 3'b111;
    return c;
  endfunction

  // Frame-level debounce: accept a frame once the last DEB frames agree.
  task automatic model_eval(input logic [8:0] f);
    int run;
    int pos;
    hist.push_back(f);
    if (hist.size() > 16) void'(hist.pop_front());
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] == f) run++;
      else break;
    end
    if (run >= DEB && f != m_acc) begin
      if ($countones(f) == 1 && (f & ~m_acc) != 9'd0) begin
        pos = 0;
        for (int b = 0; b < 9; b++) if (f[b]) pos = b;
        if (mq.size() < DEPTH) mq.push_back(4'(pos));
        else m_ovf = 1'b1;
      end
      m_acc = f;
    end
  endtask

  task automatic model_clear_all();
    mq.delete();
    hist.delete();
    m_acc = 9'd0;
    m_ovf = 1'b0;
  endtask

  // Called at a negedge with the scanner idle; returns at the negedge after
  // the IDLE->DRIVE transition.
  task automatic start_scan();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full frame with keys held; consumer readiness drawn per cycle.
  task automatic run_frame(input logic [8:0] keys, input int ready_pct, input bit clr);
    bit do_pop;
    pressed = keys;
    for (int i = 0; i < FRAME; i++) begin
      key_ready = ($urandom_range(99) < ready_pct);
      clear_overflow = clr && (i == 5);
      check_eq("column", 32'(column), 32'(exp_column(i)));
      check_eq("key_valid", 32'(key_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check_eq("key_position", 32'(key_position), 32'(mq[0]));
      do_pop = key_ready && (mq.size() != 0);
      @(posedge clk);
      if (do_pop) void'(mq.pop_front());
      if (clr && i == 5) m_ovf = 1'b0;
      if (i == FRAME - 1) model_eval(keys);
      @(negedge clk);
    end
    key_ready = 1'b0;
    clear_overflow = 1'b0;
    check_eq("key_held", 32'(key_held), 32'(m_acc != 9'd0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Partial frame, then enable drops; columns must park the next cycle.
  task automatic abort_frame(input logic [8:0] keys, input int n);
    pressed = keys;
    key_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_eq("column_abort", 32'(column), 32'(exp_column(i)));
      @(posedge clk);
      @(negedge clk);
    end
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("column_idle", 32'(column), 32'h7);
    hist.delete();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("column_idle_hold", 32'(column), 32'h7);
    end
  endtask

  logic [8:0] pat;
  int         nfr;
  int         rpct;
  int         sel;
  int         press_seq[5] = '{1, 2, 3, 4, 6};

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    enable = 1'b0;
    pressed = 9'd0;
    key_ready = 1'b0;
    clear_overflow = 1'b0;
    model_clear_all();

    #23;
    check_eq("rst_column", 32'(column), 32'h7);
    check_eq("rst_key_valid", 32'(key_valid), 32'h0);
    check_eq("rst_key_position", 32'(key_position), 32'h0);
    check_eq("rst_key_held", 32'(key_held), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_column", 32'(column), 32'h7);
    end

    // idle scanning, then a single press of key 5 and its release
    start_scan();
    run_frame(9'd0, 0, 1'b0);
    run_frame(9'd0, 0, 1'b0);
    run_frame(9'b000100000, 0, 1'b0);
    run_frame(9'b000100000, 0, 1'b0);
    check_eq("single_valid", 32'(key_valid), 32'h1);
    check_eq("single_pos", 32'(key_position), 32'h5);
    run_frame(9'b000100000, 0, 1'b0);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);

    // bounce on key 0, then stable
    for (int b = 0; b < 4; b++) run_frame((b % 2 == 0) ? 9'd1 : 9'd0, 0, 1'b0);
    run_frame(9'd1, 0, 1'b0);
    run_frame(9'd1, 0, 1'b0);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);

    // multi-key: 0 and 8 together, then release 8
    run_frame(9'h101, 0, 1'b0);
    run_frame(9'h101, 0, 1'b0);
    run_frame(9'h001, 0, 1'b0);
    run_frame(9'h001, 0, 1'b0);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);

    // overflow: five events into a four-deep queue, drain, then clear
    foreach (press_seq[p]) begin
      run_frame(9'd1 << press_seq[p], 0, 1'b0);
      run_frame(9'd1 << press_seq[p], 0, 1'b0);
      run_frame(9'd0, 0, 1'b0);
      run_frame(9'd0, 0, 1'b0);
    end
    check_eq("ovf_set", 32'(overflow), 32'h1);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 0, 1'b1);
    check_eq("ovf_cleared", 32'(overflow), 32'h0);

    // randomized key patterns and consumer behaviour
    for (int s = 0; s < 30; s++) begin
      sel = $urandom_range(9);
      if (sel < 2)      pat = 9'd0;
      else if (sel < 8) pat = 9'd1 << $urandom_range(8);
      else              pat = 9'($urandom_range(511));
      nfr = $urandom_range(1, 3);
      sel = $urandom_range(2);
      rpct = (sel == 0) ? 0 : ((sel == 1) ? 50 : 100);
      for (int f = 0; f < nfr; f++) run_frame(pat, rpct, 1'b0);
    end
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);
    run_frame(9'd0, 100, 1'b0);

    // enable drops during column 1; re-enable needs two fresh frames
    run_frame(9'b010000000, 0, 1'b0);
    abort_frame(9'b010000000, SCAN_DIV + 1);
    start_scan();
    run_frame(9'b010000000, 0, 1'b0);
    check_eq("abort_no_early_event", 32'(key_valid), 32'(mq.size() != 0));
    run_frame(9'b010000000, 0, 1'b0);
    check_eq("abort_event_valid", 32'(key_valid), 32'h1);

    // asynchronous reset in the middle of a DRIVE slot
    pressed = 9'b010000000;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_clear_all();
    check_eq("midrst_column", 32'(column), 32'h7);
    check_eq("midrst_key_valid", 32'(key_valid), 32'(mq.size() != 0));
    check_eq("midrst_key_held", 32'(key_held), 32'h0);
    check_eq("midrst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    enable = 1'b0;
    pressed = 9'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_scan();
    run_frame(9'd0, 0, 1'b0);
    run_frame(9'd0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan_sequencer.md
Name: keypad_scan_sequencer

Overview:
Sequences the 3x3 whack-a-mole keypad matrix from the 50 MHz system clock using enable-based timing (no derived clocks). It drives one active-low column at a time, samples the rows, and debounces each full 9-key frame. Each debounced single-key press becomes a position event (0-8), queued in a small FIFO for the game logic, which pops events with a valid/ready handshake.

Parameters:
SCAN_DIV, 50000, clk cycles per column slot including the sample cycle (1 ms at 50 MHz); legal range 2 or more
DEBOUNCE_SCANS, 4, consecutive identical frames required before the accepted key state changes; legal range 1-15
FIFO_DEPTH, 4, key event queue depth; power of 2, 2-16

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low; all state is cleared while low
enable  in  1  scanning enable; low parks the block in IDLE
row  in  3  keypad rows, active-low with pull-ups; row[r] low means a key in row r of the driven column is down
column  out  3  column strobes, active-low; at most one bit low
key_valid  out  1  FIFO non-empty; key_position is valid
key_position  out  4  FIFO head, position = 3*row + column (0-8)
key_ready  in  1  consumer accepts the head when key_valid && key_ready
key_held  out  1  accepted state has at least one key down
overflow  out  1  sticky flag: an event was dropped because the FIFO was full
clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset values: column=3'b111, key_valid=0, key_position=0, key_held=0, overflow=0, FIFO empty, accepted state 9'b0, stable count 0, state IDLE.
- States: IDLE, DRIVE, SAMPLE, EVAL. Column index col runs 0-2. Slot counter width is $clog2(SCAN_DIV).
- IDLE: column=111. When enable=1, go to DRIVE with col=0 and slot counter 0 on the next cycle.
- DRIVE: column[col] is driven low and the other bits high. Stay SCAN_DIV-1 cycles to let the lines settle, then go to SAMPLE.
- SAMPLE: 1 cycle, column still driven. Latch frame[3*r+col] = ~row[r] for r=0-2. If col<2: col++ and go to DRIVE. If col=2: go to EVAL.
- EVAL: 1 cycle, column=111. Frame period is 3*SCAN_DIV+1 cycles.
  - If frame==prev_frame, stable_cnt saturates at DEBOUNCE_SCANS; otherwise stable_cnt=1. prev_frame<=frame.
  - If stable_cnt reaches DEBOUNCE_SCANS in this EVAL and frame!=accepted: accepted<=frame. A press event is generated only when the new accepted has exactly one bit set and that bit was 0 in the old accepted.
  - Multi-key frames update accepted but never generate an event. Releases generate no event.
  - After EVAL: go to DRIVE col=0 if enable=1, else IDLE.
- enable falling mid-frame: go to IDLE next cycle, discard the partial frame, reset stable_cnt to 0. accepted and FIFO are kept.
- key_held = |accepted, registered.
- FIFO behaviour:
  - Push on event. Pop on key_valid && key_ready.
  - key_valid and key_position update the cycle after a push into an empty FIFO (1-cycle latency).
  - Push while full without a simultaneous pop: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop while empty: ignored.
- overflow: clear_overflow clears it. If clear and a drop coincide, set wins.
- Asynchronous reset mid-frame returns everything to the reset values immediately.

Decomposition:
- Shared package keypad_pkg:
  - constants NUM_ROWS=3, NUM_COLS=3, NUM_KEYS=9, POS_W=4
  - state enumeration (IDLE, DRIVE, SAMPLE, EVAL)
  - a function mapping row and column to position
- Sub-module key_event_fifo (parameter DEPTH, data POS_W): push, push_data, pop, valid, head, full; same clk/reset. The top owns the FSM, slot counter and debounce.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, frame=13 cycles):
- Reset and enable scan: reset low then high, enable=1, rows=111 -> column sequence 110,101,011 with each low for 4 cycles, then 111 for 1 cycle; key_valid=0; key_held=0.
- Single press: row[1] low only while column[2] is low, for 3 frames -> exactly one event, key_position=5 and key_valid=1 after the 2nd stable EVAL; key_held=1; releasing generates no new event and key_held=0.
- Bounce: key 0 toggled every frame for 4 frames, then stable -> no event until 2 consecutive identical frames, then one event with position 0.
- Multi-key: keys 0 and 8 pressed together -> no event and key_held=1; release 8 with 0 still held -> no event (bit 0 was already accepted).
- Overflow: key_ready=0, 5 distinct press/release sequences (positions 1,2,3,4,6) -> FIFO holds 1,2,3,4; overflow=1. Then key_ready=1 -> pops 1,2,3,4 in order. clear_overflow -> overflow=0.
- Enable and reset mid-frame: enable=0 during col=1 -> column=111 next cycle; re-enable restarts at col=0 and needs 2 fresh frames. Asserting reset during DRIVE -> column=111 and FIFO empty immediately.
